// File: rtl/psum_bram_arbiter.sv
// psum_bram_arbiter: shares psum BRAM port A between the PS BRAM controller and N_PORT
// round-robin PL requesters; every ownership change drains in-flight PL reads first.
module psum_bram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_BYTE   = 4,
  parameter int REG_WIDTH  = 32,
  parameter int N_PORT     = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [REG_WIDTH-1:0]         i_conf_ctrl,
  input  logic [ADDR_WIDTH-1:0]        bram_addr_a,
  input  logic [DATA_WIDTH-1:0]        bram_wrdata_a,
  output logic [DATA_WIDTH-1:0]        bram_rddata_a,
  input  logic                         bram_en_a,
  input  logic                         bram_rst_a,
  input  logic [NUM_BYTE-1:0]          bram_we_a,
  input  logic [N_PORT-1:0]            pl_req,
  input  logic [N_PORT*ADDR_WIDTH-1:0] pl_addr,
  input  logic [N_PORT*DATA_WIDTH-1:0] pl_wdat,
  input  logic [N_PORT*NUM_BYTE-1:0]   pl_wren,
  output logic [N_PORT-1:0]            pl_gnt,
  output logic [N_PORT-1:0]            pl_rvalid,
  output logic [DATA_WIDTH-1:0]        pl_rdat,
  output logic                         o_ps_owned,
  output logic [ADDR_WIDTH-1:0]        addra,
  output logic [DATA_WIDTH-1:0]        dina,
  output logic                         ena,
  output logic                         rsta,
  output logic [NUM_BYTE-1:0]          wea,
  input  logic [DATA_WIDTH-1:0]        douta
);

  localparam int PW    = (N_PORT > 1) ? $clog2(N_PORT) : 1;
  localparam int DEPTH = RD_LATENCY + 1;

  typedef enum logic [1:0] {
    PL_OWN      = 2'd0,
    DRAIN_TO_PS = 2'd1,
    PS_OWN      = 2'd2,
    DRAIN_TO_PL = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [1:0]    drain_cnt, drain_cnt_next;
  logic [PW-1:0] rr_ptr;
  logic          ps_sel;
  logic          unused_conf;

  assign ps_sel      = i_conf_ctrl[0];
  assign unused_conf = ^i_conf_ctrl[REG_WIDTH-1:1];

  // Unpack the flattened per-port request buses.
  logic [ADDR_WIDTH-1:0] port_addr [N_PORT];
  logic [DATA_WIDTH-1:0] port_wdat [N_PORT];
  logic [NUM_BYTE-1:0]   port_wren [N_PORT];

  for (genvar gi = 0; gi < N_PORT; gi++) begin : g_unpack
    assign port_addr[gi] = pl_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign port_wdat[gi] = pl_wdat[gi*DATA_WIDTH +: DATA_WIDTH];
    assign port_wren[gi] = pl_wren[gi*NUM_BYTE +: NUM_BYTE];
  end

  // Round-robin pick: first requester at or after rr_ptr. Reset also masks the grant.
  logic          gnt_any;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] cand;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (rst_n && (state == PL_OWN) && !ps_sel) begin
      for (int k = 0; k < N_PORT; k++) begin
        cand = PW'((int'(rr_ptr) + k) % N_PORT);
        if (!gnt_any && pl_req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  always_comb begin
    pl_gnt = '0;
    if (gnt_any) pl_gnt[gnt_idx] = 1'b1;
  end

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdat;
  logic [NUM_BYTE-1:0]   sel_wren;
  logic                  sel_is_read;

  assign sel_addr    = port_addr[gnt_idx];
  assign sel_wdat    = port_wdat[gnt_idx];
  assign sel_wren    = port_wren[gnt_idx];
  assign sel_is_read = (sel_wren == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (gnt_idx == PW'(N_PORT - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Registered PL issue stage: a grant in cycle t reaches the BRAM at t+1.
  logic                  issue_en;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [DATA_WIDTH-1:0] issue_wdat;
  logic [NUM_BYTE-1:0]   issue_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_en   <= 1'b0;
      issue_addr <= '0;
      issue_wdat <= '0;
      issue_we   <= '0;
    end else begin
      issue_en <= gnt_any;
      issue_we <= gnt_any ? sel_wren : '0;
      if (gnt_any) begin
        issue_addr <= sel_addr;
        issue_wdat <= sel_wdat;
      end
    end
  end

  // Read tag pipe; stage DEPTH-1 lines up with douta for the issued read.
  logic [DEPTH-1:0] tag_valid;
  logic [PW-1:0]    tag_port [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid[0] <= 1'b0;
      tag_port[0]  <= '0;
    end else begin
      tag_valid[0] <= gnt_any && sel_is_read;
      tag_port[0]  <= gnt_idx;
    end
  end

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_tag
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tag_valid[gi] <= 1'b0;
        tag_port[gi]  <= '0;
      end else begin
        tag_valid[gi] <= tag_valid[gi-1];
        tag_port[gi]  <= tag_port[gi-1];
      end
    end
  end

  always_comb begin
    pl_rvalid = '0;
    pl_rdat   = '0;
    if (tag_valid[DEPTH-1]) begin
      pl_rvalid[tag_port[DEPTH-1]] = 1'b1;
      pl_rdat                      = douta;
    end
  end

  // Ownership FSM; each drain lasts RD_LATENCY+1 cycles and cannot be aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PL_OWN;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    case (state)
      PL_OWN: begin
        if (ps_sel) begin
          state_next     = DRAIN_TO_PS;
          drain_cnt_next = '0;
        end
      end
      DRAIN_TO_PS: begin
        if (drain_cnt == 2'(RD_LATENCY)) begin
          state_next     = PS_OWN;
          drain_cnt_next = '0;
        end else begin
          drain_cnt_next = drain_cnt + 2'd1;
        end
      end
      PS_OWN: begin
        if (!ps_sel) begin
          state_next     = DRAIN_TO_PL;
          drain_cnt_next = '0;
        end
      end
      DRAIN_TO_PL: begin
        if (drain_cnt == 2'(RD_LATENCY)) begin
          state_next     = PL_OWN;
          drain_cnt_next = '0;
        end else begin
          drain_cnt_next = drain_cnt + 2'd1;
        end
      end
      default: state_next = PL_OWN;
    endcase
  end

  // BRAM port A steering.
  always_comb begin
    addra         = issue_addr;
    dina          = issue_wdat;
    ena           = 1'b0;
    wea           = '0;
    rsta          = 1'b0;
    bram_rddata_a = '0;
    case (state)
      PS_OWN: begin
        addra         = bram_addr_a;
        dina          = bram_wrdata_a;
        ena           = bram_en_a;
        wea           = bram_we_a;
        rsta          = bram_rst_a;
        bram_rddata_a = douta;
      end
      PL_OWN: begin
        ena = issue_en;
        wea = issue_we;
      end
      default: ;
    endcase
  end

  assign o_ps_owned = (state == PS_OWN);

endmodule

// File: tb/tb_psum_bram_arbiter.sv
// Bench for psum_bram_arbiter: directed ownership/arbitration scenarios followed by random
// traffic, all checked cycle by cycle against a transaction-level reference model.
module tb_psum_bram_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NB = 4;
  localparam int RW = 32;
  localparam int N  = 4;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] conf = '0;
  logic [AW-1:0] ps_addr = '0;
  logic [DW-1:0] ps_wdat = '0;
  logic [DW-1:0] ps_rdat;
  logic          ps_en = 1'b0;
  logic          ps_rst = 1'b0;
  logic [NB-1:0] ps_we = '0;
  logic [N-1:0]  pl_req = '0;
  logic [N*AW-1:0] pl_addr = '0;
  logic [N*DW-1:0] pl_wdat = '0;
  logic [N*NB-1:0] pl_wren = '0;
  logic [N-1:0]  pl_gnt, pl_rvalid;
  logic [DW-1:0] pl_rdat;
  logic          ps_owned;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina, douta;
  logic          ena, rsta;
  logic [NB-1:0] wea;

  always #5 clk = ~clk;

  psum_bram_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BYTE(NB), .REG_WIDTH(RW),
    .N_PORT(N), .RD_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_conf_ctrl(conf),
    .bram_addr_a(ps_addr), .bram_wrdata_a(ps_wdat), .bram_rddata_a(ps_rdat),
    .bram_en_a(ps_en), .bram_rst_a(ps_rst), .bram_we_a(ps_we),
    .pl_req(pl_req), .pl_addr(pl_addr), .pl_wdat(pl_wdat), .pl_wren(pl_wren),
    .pl_gnt(pl_gnt), .pl_rvalid(pl_rvalid), .pl_rdat(pl_rdat), .o_ps_owned(ps_owned),
    .addra(addra), .dina(dina), .ena(ena), .rsta(rsta), .wea(wea), .douta(douta)
  );

  function automatic logic [31:0] init_word(int i);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(i);
    h = 16'(i);
    return (i == 4) ? 32'hA5A5_0001 : {8'hC3, b, 16'h1234 ^ h};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // BRAM behavioural model: read-first, RL-cycle registered read.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_pipe [RL];
  bit            mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (ena) begin
      for (int b = 0; b < NB; b++) if (wea[b]) mem[addra[9:2]][b*8 +: 8] <= dina[b*8 +: 8];
      rd_pipe[0] <= mem[addra[9:2]];
    end
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign douta = rd_pipe[RL-1];

  // Reference model state.
  typedef struct { int due; int port; logic [31:0] data; } rd_t;
  rd_t           rq[$];
  logic [31:0]   ref_mem [256];
  int            phase;          // 0 PL owns, 1 draining to PS, 2 PS owns, 3 draining to PL
  int            drain_left;
  int            rr;
  bit            iss_v;
  int            iss_port;
  logic [AW-1:0] iss_addr;
  logic [DW-1:0] iss_wdat;
  logic [NB-1:0] iss_we;
  bit            ps_exp_v;
  logic [31:0]   ps_exp;
  int            cyc;
  int            last_gi;
  int            errors = 0;
  int            checks = 0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_port(int p, logic [AW-1:0] a, logic [DW-1:0] d, logic [NB-1:0] w);
    pl_addr[p*AW +: AW] = a;
    pl_wdat[p*DW +: DW] = d;
    pl_wren[p*NB +: NB] = w;
  endtask

  task automatic model_reset();
    phase = 0; drain_left = 0; rr = 0; iss_v = 0; iss_port = 0;
    ps_exp_v = 0; rq.delete(); last_gi = -1;
  endtask

  // One clock: check this cycle's outputs at negedge, then advance the model at posedge.
  task automatic do_cycle();
    logic [N-1:0] eg, er;
    int           gsel, idx;
    @(negedge clk);
    gsel = -1;
    eg   = '0;
    if (phase == 0 && !conf[0])
      for (int k = 0; k < N; k++) if (gsel < 0 && pl_req[(rr + k) % N]) gsel = (rr + k) % N;
    if (gsel >= 0) eg[gsel] = 1'b1;
    check_eq("gnt", 64'(pl_gnt), 64'(eg));
    er = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      er[rq[0].port] = 1'b1;
      check_eq("rdat", 64'(pl_rdat), 64'(rq[0].data));
      $display("txn cyc=%0d port=%0d rdat=%h exp=%h", cyc, rq[0].port, pl_rdat, rq[0].data);
    end
    check_eq("rvalid", 64'(pl_rvalid), 64'(er));
    check_eq("ps_owned", 64'(ps_owned), 64'(phase == 2));
    if (phase == 2) begin
      check_eq("ps_ena", 64'(ena), 64'(ps_en));
      check_eq("ps_wea", 64'(wea), 64'(ps_we));
      check_eq("ps_addra", 64'(addra), 64'(ps_addr));
      check_eq("ps_dina", 64'(dina), 64'(ps_wdat));
      check_eq("ps_rsta", 64'(rsta), 64'(ps_rst));
      if (ps_exp_v) check_eq("ps_rddata", 64'(ps_rdat), 64'(ps_exp));
    end else begin
      check_eq("ena", 64'(ena), 64'(iss_v));
      check_eq("wea", 64'(wea), 64'(iss_v ? iss_we : '0));
      if (iss_v) begin
        check_eq("addra", 64'(addra), 64'(iss_addr));
        check_eq("dina", 64'(dina), 64'(iss_wdat));
      end
      check_eq("rsta", 64'(rsta), 64'd0);
      check_eq("ps_rddata_idle", 64'(ps_rdat), 64'd0);
    end
    @(posedge clk);
    if (iss_v) begin
      idx = int'(iss_addr[9:2]);
      if (iss_we != '0) ref_mem[idx] = merge(ref_mem[idx], iss_wdat, iss_we);
      else rq.push_back('{due: cyc + RL, port: iss_port, data: ref_mem[idx]});
    end
    ps_exp_v = 0;
    if (phase == 2 && ps_en) begin
      idx = int'(ps_addr[9:2]);
      if (ps_we != '0) ref_mem[idx] = merge(ref_mem[idx], ps_wdat, ps_we);
      else begin ps_exp = ref_mem[idx]; ps_exp_v = 1; end
    end
    iss_v = (gsel >= 0);
    if (gsel >= 0) begin
      iss_port = gsel;
      iss_addr = pl_addr[gsel*AW +: AW];
      iss_wdat = pl_wdat[gsel*DW +: DW];
      iss_we   = pl_wren[gsel*NB +: NB];
      rr       = (gsel + 1) % N;
    end
    case (phase)
      0: if (conf[0]) begin phase = 1; drain_left = RL + 1; end
      2: if (!conf[0]) begin phase = 3; drain_left = RL + 1; end
      default: begin
        drain_left--;
        if (drain_left == 0) phase = (phase + 1) % 4;
      end
    endcase
    if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
    last_gi = gsel;
    cyc++;
    #1;
  endtask

  task automatic check_all_zero(string tag);
    check_eq({tag, "_gnt"}, 64'(pl_gnt), 64'd0);
    check_eq({tag, "_rvalid"}, 64'(pl_rvalid), 64'd0);
    check_eq({tag, "_rdat"}, 64'(pl_rdat), 64'd0);
    check_eq({tag, "_ena"}, 64'(ena), 64'd0);
    check_eq({tag, "_wea"}, 64'(wea), 64'd0);
    check_eq({tag, "_addra"}, 64'(addra), 64'd0);
    check_eq({tag, "_dina"}, 64'(dina), 64'd0);
    check_eq({tag, "_rsta"}, 64'(rsta), 64'd0);
    check_eq({tag, "_ps_owned"}, 64'(ps_owned), 64'd0);
    check_eq({tag, "_ps_rddata"}, 64'(ps_rdat), 64'd0);
  endtask

  task automatic gen_reqs();
    for (int p = 0; p < N; p++) begin
      if (p == last_gi) pl_req[p] = 1'b0;
      if (!pl_req[p] && $urandom_range(0, 1) == 1) begin
        pl_req[p] = 1'b1;
        set_port(p, AW'(32'h20 + 4 * $urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 1) == 1) ? NB'($urandom) : '0);
      end
    end
    ps_en   = ($urandom_range(0, 1) == 1);
    ps_addr = AW'(32'h20 + 4 * $urandom_range(0, 7));
    ps_wdat = $urandom;
    ps_we   = ($urandom_range(0, 1) == 1) ? NB'($urandom) : '0;
    ps_rst  = ($urandom_range(0, 7) == 0);
    if ($urandom_range(0, 39) == 0) conf[0] = ~conf[0];
  endtask

  initial begin
    bit did_reset;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    model_reset();
    cyc = 0;
    did_reset = 0;

    // Reset with every port requesting: nothing may be granted or driven.
    pl_req = '1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    pl_req = '0;
    rst_n  = 1'b1;

    // All four ports request back to back from rr_ptr=0.
    pl_req = '1;
    for (int p = 0; p < N; p++) set_port(p, AW'(32'h20 + 4 * p), 32'h0, '0);
    repeat (8) do_cycle();
    pl_req = '0;
    repeat (3) do_cycle();

    // Port 2 single read of the preloaded word at 0x10.
    pl_req = 4'b0100;
    set_port(2, 32'h10, 32'h0, '0);
    do_cycle();
    pl_req = '0;
    repeat (3) do_cycle();

    // Port 1 partial write, then port 0 reads the same word right behind it.
    pl_req = 4'b0010;
    set_port(1, 32'h20, 32'hDEADBEEF, 4'b0011);
    do_cycle();
    pl_req = 4'b0001;
    set_port(0, 32'h20, 32'h0, '0);
    do_cycle();
    pl_req = '0;
    repeat (3) do_cycle();

    // Port 3 read granted, PS ownership requested immediately afterwards.
    pl_req = 4'b1000;
    set_port(3, 32'h24, 32'h0, '0);
    do_cycle();
    pl_req  = '0;
    conf[0] = 1'b1;
    repeat (5) do_cycle();

    // PS write then read back while PL requests are held off.
    pl_req = '1;
    ps_en = 1'b1; ps_addr = 32'h40; ps_wdat = 32'h12345678; ps_we = 4'hF;
    do_cycle();
    ps_we = '0;
    do_cycle();
    ps_en = 1'b0;
    do_cycle();
    conf[0] = 1'b0;
    repeat (6) do_cycle();
    pl_req = '0;
    repeat (3) do_cycle();

    // Random traffic with one asynchronous reset while reads are in flight.
    for (int i = 0; i < 3000; i++) begin
      gen_reqs();
      do_cycle();
      if (!did_reset && ((i > 1500 && rq.size() > 0 && pl_req != '0) || i == 2800)) begin
        gen_reqs();
        pl_req[0] = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        did_reset = 1;
      end
    end
    pl_req = '0;
    conf   = '0;
    repeat (8) do_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
